// File: rtl/hydra_pkg.sv
// Shared definitions for the hydra read-sink: header layout, FSM states,
// and error-vector bit positions.
package hydra_pkg;

  localparam int LEN_MSB  = 15;
  localparam int LEN_LSB  = 7;
  localparam int PRI_MSB  = 6;
  localparam int PRI_LSB  = 4;
  localparam int DEST_MSB = 3;
  localparam int DEST_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_SOP,
    WAIT_HDR,
    DATA,
    DONE
  } state_t;

  localparam int ERR_DEST    = 0;
  localparam int ERR_LEN     = 1;
  localparam int ERR_DATA    = 2;
  localparam int ERR_PROTO   = 3;
  localparam int ERR_TIMEOUT = 4;

  function automatic logic [15:0] mk_hdr(
    input logic [8:0] len,
    input logic [2:0] pri,
    input logic [3:0] dest
  );
    return {len, pri, dest};
  endfunction

endpackage

// File: rtl/hydra_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async high), i_clr, i_inc, o_q (holds at MAX).
module hydra_sat_cnt #(
  parameter int           W   = 16,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // clr together with inc loads 1, so a start-of-window
  // cycle can count itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= W'(i_inc);
    end else if (i_inc && r_q != MAX) begin
      r_q <= r_q + W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/hydra_rd_sink.sv
// Per-port read-interface consumer: requests, parses and checks packets.
// Ports: clk/rst, enable, ready out; rd_* in; pkt_* report and counters out.
module hydra_rd_sink
  import hydra_pkg::*;
#(
  parameter int PORT_ID    = 0,
  parameter int TIMEOUT    = 1024,
  parameter int CHECK_DATA = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        ready,
  input  logic        rd_sop,
  input  logic        rd_vld,
  input  logic [15:0] rd_data,
  input  logic        rd_eop,
  output logic        pkt_done,
  output logic [8:0]  pkt_len,
  output logic [2:0]  pkt_prior,
  output logic [15:0] pkt_latency,
  output logic [15:0] pkt_duration,
  output logic [4:0]  pkt_err,
  output logic [31:0] pkt_cnt,
  output logic [31:0] err_cnt
);

  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

  state_t r_state;
  state_t w_nxt;

  logic [8:0] r_len;
  logic [2:0] r_prior;
  logic       r_dest_err;
  logic       r_data_err;
  logic [4:0] r_err;

  logic [GW-1:0] w_gap;
  logic [9:0]    w_beat;
  logic [9:0]    w_beat_eop;
  logic [15:0]   w_lat;
  logic [15:0]   w_dur;
  logic          w_bad;
  logic          w_len_bad;

  logic w_start;
  logic w_hdr;
  logic w_beat_inc;
  logic w_lat_inc;
  logic w_dur_inc;
  logic w_gap_inc;
  logic w_gap_clr;
  logic w_fin;
  logic w_f_to;
  logic w_f_proto;
  logic w_f_eop;
  logic w_f_bad;
  logic w_stray;
  logic [4:0] w_err;

  assign w_bad = (CHECK_DATA != 0) &&
                 (rd_data != {6'd0, w_beat});

  // Beat count as it stands after this cycle's beat,
  // for the vld+eop-together case.
  assign w_beat_eop = (rd_vld && w_beat != 10'd512) ?
                      w_beat + 10'd1 : w_beat;
  assign w_len_bad  = w_beat_eop != {1'b0, r_len};

  always_comb begin
    w_nxt      = r_state;
    w_start    = 1'b0;
    w_hdr      = 1'b0;
    w_beat_inc = 1'b0;
    w_lat_inc  = 1'b0;
    w_dur_inc  = 1'b0;
    w_gap_inc  = 1'b0;
    w_gap_clr  = 1'b0;
    w_fin      = 1'b0;
    w_f_to     = 1'b0;
    w_f_proto  = 1'b0;
    w_f_eop    = 1'b0;
    w_f_bad    = 1'b0;
    w_stray    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_stray = rd_vld | rd_eop;
        if (enable) w_nxt = REQ;
      end
      REQ: begin
        w_stray = rd_vld | rd_eop;
        w_nxt   = WAIT_SOP;
      end
      WAIT_SOP: begin
        if (rd_sop) begin
          w_start = 1'b1;
          w_nxt   = WAIT_HDR;
        end else begin
          w_stray = rd_vld | rd_eop;
        end
      end
      WAIT_HDR: begin
        w_dur_inc = 1'b1;
        if (rd_sop || rd_eop) begin
          w_f_proto = 1'b1;
          w_fin     = 1'b1;
        end else if (rd_vld) begin
          w_hdr     = 1'b1;
          w_gap_clr = 1'b1;
          w_nxt     = DATA;
        end else begin
          w_lat_inc = 1'b1;
          if (w_gap == GAP_LAST) begin
            w_f_to = 1'b1;
            w_fin  = 1'b1;
          end else begin
            w_gap_inc = 1'b1;
          end
        end
      end
      DATA: begin
        w_dur_inc = 1'b1;
        if (rd_sop) begin
          w_f_proto = 1'b1;
          w_fin     = 1'b1;
        end else begin
          if (rd_vld) begin
            w_beat_inc = 1'b1;
            w_gap_clr  = 1'b1;
            w_f_bad    = w_bad;
          end
          if (rd_eop) begin
            w_f_eop = 1'b1;
            w_fin   = 1'b1;
          end else if (!rd_vld) begin
            if (w_gap == GAP_LAST) begin
              w_f_to = 1'b1;
              w_fin  = 1'b1;
            end else begin
              w_gap_inc = 1'b1;
            end
          end
        end
      end
      DONE: begin
        w_nxt = IDLE;
      end
      default: begin
        w_nxt = IDLE;
      end
    endcase
    if (w_fin) w_nxt = DONE;
  end

  always_comb begin
    w_err              = '0;
    w_err[ERR_DEST]    = r_dest_err;
    w_err[ERR_LEN]     = w_f_eop & w_len_bad;
    w_err[ERR_DATA]    = r_data_err | w_f_bad;
    w_err[ERR_PROTO]   = w_f_proto;
    w_err[ERR_TIMEOUT] = w_f_to;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_prior    <= '0;
      r_dest_err <= 1'b0;
      r_data_err <= 1'b0;
      r_err      <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_start) begin
        r_len      <= '0;
        r_prior    <= '0;
        r_dest_err <= 1'b0;
        r_data_err <= 1'b0;
      end
      if (w_hdr) begin
        r_len      <= rd_data[LEN_MSB:LEN_LSB];
        r_prior    <= rd_data[PRI_MSB:PRI_LSB];
        r_dest_err <= rd_data[DEST_MSB:DEST_LSB] != 4'(PORT_ID);
      end
      if (w_f_bad) r_data_err <= 1'b1;
      if (w_fin)   r_err      <= w_err;
    end
  end

  hydra_sat_cnt #(.W(16)) u_lat (
    .clk(clk), .rst(rst),
    .i_clr(w_start), .i_inc(w_lat_inc),
    .o_q(w_lat)
  );

  hydra_sat_cnt #(.W(16)) u_dur (
    .clk(clk), .rst(rst),
    .i_clr(w_start), .i_inc(w_dur_inc | w_start),
    .o_q(w_dur)
  );

  hydra_sat_cnt #(.W(GW)) u_gap (
    .clk(clk), .rst(rst),
    .i_clr(w_start | w_gap_clr), .i_inc(w_gap_inc),
    .o_q(w_gap)
  );

  hydra_sat_cnt #(.W(10), .MAX(10'd512)) u_beat (
    .clk(clk), .rst(rst),
    .i_clr(w_hdr), .i_inc(w_beat_inc),
    .o_q(w_beat)
  );

  hydra_sat_cnt #(.W(32)) u_pkt_cnt (
    .clk(clk), .rst(rst),
    .i_clr(1'b0), .i_inc(w_fin),
    .o_q(pkt_cnt)
  );

  hydra_sat_cnt #(.W(32)) u_err_cnt (
    .clk(clk), .rst(rst),
    .i_clr(1'b0),
    .i_inc((w_fin && w_err != 5'd0) || w_stray),
    .o_q(err_cnt)
  );

  assign ready        = (r_state == REQ);
  assign pkt_done     = (r_state == DONE);
  assign pkt_len      = r_len;
  assign pkt_prior    = r_prior;
  assign pkt_latency  = w_lat;
  assign pkt_duration = w_dur;
  assign pkt_err      = r_err;

endmodule

// File: doc/hydra_rd_sink.md
Name: hydra_rd_sink

Overview:
- Synthesizable per-port consumer for the switch read interface (ready / rd_sop / rd_vld / rd_data / rd_eop). One instance sits on each of the 16 egress ports.
- Requests one packet at a time with a single-cycle ready pulse, then parses the header beat and receives the payload.
- Checks framing, destination, beat count and the incrementing payload pattern.
- Reports per-packet latency, length and error flags, and keeps saturating packet and error counters for stress runs.

Parameters:
- PORT_ID, 0: egress port index 0..15; header dest must equal it.
- TIMEOUT, 1024: maximum idle cycles allowed between sop and the header beat, or between consecutive beats, before abort.
- CHECK_DATA, 1: 1 = payload beat k must equal k[15:0]; 0 = payload check disabled.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  when high, the block requests packets continuously.
- ready  out  1  registered one-cycle request pulse to the switch.
- rd_sop  in  1  start of packet.
- rd_vld  in  1  data beat valid; the first beat after sop is the header.
- rd_data  in  16  beat data; header layout is [15:7] length, [6:4] prior, [3:0] dest.
- rd_eop  in  1  end of packet.
- pkt_done  out  1  one-cycle pulse; all pkt_* outputs are valid in this cycle.
- pkt_len  out  9  header length field.
- pkt_prior  out  3  header priority field.
- pkt_latency  out  16  cycles strictly between sop and the header beat; saturates at 16'hFFFF.
- pkt_duration  out  16  cycles from sop to eop inclusive; saturates at 16'hFFFF.
- pkt_err  out  5  error vector: {timeout, proto, data, len, dest}.
- pkt_cnt  out  32  packets completed, including errored ones; saturating.
- err_cnt  out  32  packets with pkt_err != 0, plus standalone proto events; saturating.

Behaviour:
- Async rst: state = IDLE; every output is 0; all counters are 0. Reset mid-packet discards the packet and produces no pkt_done.

State machine:
- IDLE: if enable, go to REQ.
- REQ: ready = 1 for exactly this cycle, then go to WAIT_SOP.
- WAIT_SOP: wait indefinitely for rd_sop; no timeout applies. On rd_sop, clear the gap counter, lat = 0 and dur = 1, then go to WAIT_HDR.
- WAIT_HDR: on rd_vld, capture the header, beat = 0, go to DATA. Otherwise increment lat and dur.
- DATA: each rd_vld beat compares rd_data against beat[15:0] when CHECK_DATA is set, then increments beat. beat is a 10-bit counter saturating at 512.
- DATA, eop: on rd_eop go to DONE. If vld and eop are asserted together, the beat is counted first.
- DONE: pkt_done = 1 for one cycle; update counters; go to IDLE. With enable still high, ready re-pulses 2 cycles after pkt_done.

Timing:
- ready is driven from the state register, not combinationally from inputs.
- dur increments every cycle from sop through eop, so a packet with eop 3 cycles after sop has dur = 4.

Error rules (latched per packet, reported at DONE):
- dest: header[3:0] != PORT_ID.
- len: beat count != header[15:7] at eop.
- data: any payload mismatch.
- timeout: gap counter reaches TIMEOUT in WAIT_HDR or DATA. Go to DONE immediately with the timeout bit set and the other bits as accumulated.
- proto, eop in WAIT_HDR: report pkt_len = 0 and go to DONE.
- proto, rd_sop in WAIT_HDR or DATA: close the current packet via DONE with proto set. The new sop is not followed; the next ready pulse restarts cleanly.
- proto, rd_vld or rd_eop in IDLE, REQ or WAIT_SOP: increment err_cnt only; no pkt_done.

Other boundary rules:
- enable low: the block finishes any in-flight packet, then stays in IDLE.
- Header length 0: eop with no payload beats is legal, with no len error.
- 32-bit counters hold at all-ones.

Decomposition:
- Package hydra_pkg holds:
  - header field positions (LEN_MSB = 15, LEN_LSB = 7, PRI 6:4, DEST 3:0);
  - the state enum {IDLE, REQ, WAIT_SOP, WAIT_HDR, DATA, DONE};
  - error bit indices ERR_DEST = 0 .. ERR_TIMEOUT = 4.
- One sub-module, hydra_sat_cnt (parameterized width, saturating increment). It is reused for lat, dur, gap, pkt_cnt and err_cnt.

Test Plan:
- Clean packet: PORT_ID = 5, enable = 1. Driver sends sop 4 cycles after ready, header {len = 31, prior = 3, dest = 5} 2 cycles later, payload 0..30, then eop. Required: pkt_done with len = 31, prior = 3, latency = 1, err = 0, pkt_cnt = 1.
- Length mismatch: header len = 40, only 39 beats before eop. Required: pkt_err = 5'b00010, err_cnt = 1.
- Data and dest errors: header dest = 6 on PORT_ID = 5, and beat 7 carries 16'h00FF. Required: pkt_err = 5'b00101.
- Timeout: TIMEOUT = 16, header received, then no vld or eop for 16 cycles. Required: pkt_done with timeout bit set; ready re-pulses 2 cycles later.
- Protocol errors: stray rd_vld in WAIT_SOP gives err_cnt += 1 and no pkt_done. A second rd_sop mid-DATA gives pkt_done with the proto bit set.
- Reset and back-to-back: assert rst mid-DATA, giving ready = 0, counters = 0 and no pkt_done. Then send 100 back-to-back 511-beat packets, giving pkt_cnt = 100, err_cnt = 0 and exactly one ready pulse per packet.
